// File: rtl/stdp_pkg.sv
// Shared types, constants and update-rule helpers for the STDP weight-update scheduler.
package stdp_pkg;
    localparam int N_SYN   = 16;
    localparam int W_WIDTH = 4;
    localparam int AGE_W   = 3;
    localparam int SEL_W   = 4;

    typedef logic [AGE_W-1:0]   age_t;
    typedef logic [W_WIDTH-1:0] weight_t;
    typedef logic [SEL_W-1:0]   sel_t;

    localparam age_t    AGE_MAX  = 3'd7;
    localparam age_t    LTP_WIN  = 3'd3;
    localparam weight_t W_MAX    = 4'd15;
    localparam weight_t W_MIN    = 4'd0;
    localparam sel_t    IDX_LAST = 4'(N_SYN - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Potentiate recent spikes, depress older ones; AGE_MAX means no spike seen.
    function automatic weight_t stdp_rule(input age_t a, input weight_t w);
        weight_t r;
        r = w;
        if (a <= LTP_WIN) begin
            if (w != W_MAX) r = w + 4'd1;
        end else if (a != AGE_MAX) begin
            if (w != W_MIN) r = w - 4'd1;
        end
        return r;
    endfunction

    // Signed spike timing: +a inside the LTP window, -(a-LTP_WIN) beyond it.
    function automatic age_t age_to_td(input age_t a);
        age_t r;
        r = '0;
        if (a <= LTP_WIN)      r = a;
        else if (a != AGE_MAX) r = LTP_WIN - a;
        return r;
    endfunction
endpackage

// File: rtl/spike_age_counter.sv
// Per-synapse saturating presynaptic spike age; a spike clears, enable advances.
module spike_age_counter
    import stdp_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       spike,
    output logic [2:0] age
);
    age_t age_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            age_q <= AGE_MAX;
        end else if (spike) begin
            age_q <= '0;
        end else if (enable && age_q != AGE_MAX) begin
            age_q <= age_q + 3'd1;
        end
    end

    assign age = age_q;
endmodule

// File: rtl/stdp_update_scheduler.sv
// On a postsynaptic rising edge, snapshots all spike ages and runs a
// select/read/write pass over every synapse weight.
module stdp_update_scheduler
    import stdp_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              postsynapSR0,
    input  logic [15:0]       presynap_spikes,
    output logic [3:0]        select,
    input  logic [3:0]        weight_rd_data,
    output logic              weight_wr_en,
    output logic [3:0]        weight_wr_data,
    output logic signed [2:0] time_difference,
    output logic              busy,
    output logic              scan_done,
    output logic              missed_post
);
    logic [N_SYN-1:0][AGE_W-1:0] age_live;
    logic [N_SYN-1:0][AGE_W-1:0] snap_q;
    state_e  state_q, state_d;
    sel_t    idx_q, idx_d;
    sel_t    sel_q;
    weight_t wnew_q;
    logic    post_q;
    logic    missed_q;
    logic    post_rise;
    age_t    cur_age;

    for (genvar gi = 0; gi < N_SYN; gi++) begin : g_age
        spike_age_counter u_age (
            .clock  (clock),
            .reset  (reset),
            .enable (enable),
            .spike  (presynap_spikes[gi]),
            .age    (age_live[gi])
        );
    end

    assign post_rise = postsynapSR0 & ~post_q;
    assign cur_age   = snap_q[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (post_rise && enable) begin
                    state_d = ST_SEL;
                    idx_d   = '0;
                end
            end
            ST_SEL:   state_d = ST_READ;
            ST_READ:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_SEL;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sel_q    <= '0;
            wnew_q   <= '0;
            snap_q   <= {N_SYN{AGE_MAX}};
            post_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            post_q  <= postsynapSR0;
            state_q <= state_d;
            idx_q   <= idx_d;
            if (state_q == ST_IDLE && state_d == ST_SEL) snap_q <= age_live;
            // select moves on entry to SEL so the memory read settles during READ
            if (state_d == ST_SEL) sel_q <= idx_d;
            if (state_q == ST_READ) wnew_q <= stdp_rule(cur_age, weight_rd_data);
            if (post_rise && state_q != ST_IDLE) missed_q <= 1'b1;
        end
    end

    assign select          = sel_q;
    assign weight_wr_en    = (state_q == ST_WRITE);
    assign weight_wr_data  = wnew_q;
    assign time_difference = (state_q == ST_READ || state_q == ST_WRITE) ? age_to_td(cur_age) : '0;
    assign busy            = (state_q != ST_IDLE);
    assign scan_done       = (state_q == ST_DONE);
    assign missed_post     = missed_q;
endmodule

// File: tb/tb_stdp_update_scheduler.sv
// Randomized and directed bench for stdp_update_scheduler against a scan-level reference model.
module tb_stdp_update_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        post;
    logic [15:0] spikes;
    logic [3:0]  select;
    logic [3:0]  rd_q;
    logic        wr_en;
    logic [3:0]  wr_data;
    logic signed [2:0] td;
    logic        busy;
    logic        scan_done;
    logic        missed_post;

    logic [15:0]      load_mask;
    logic [15:0][3:0] load_vec;
    logic [3:0]       mem [16];

    always #5 clk = ~clk;

    stdp_update_scheduler dut (
        .clock           (clk),
        .reset           (rst),
        .enable          (en),
        .postsynapSR0    (post),
        .presynap_spikes (spikes),
        .select          (select),
        .weight_rd_data  (rd_q),
        .weight_wr_en    (wr_en),
        .weight_wr_data  (wr_data),
        .time_difference (td),
        .busy            (busy),
        .scan_done       (scan_done),
        .missed_post     (missed_post)
    );

    // Synchronous-read weight store with a bench-side preload port.
    always @(posedge clk) begin
        rd_q <= mem[select];
        if (wr_en) mem[select] <= wr_data;
        for (int i = 0; i < 16; i++)
            if (load_mask[i]) mem[i] <= load_vec[i];
    end

    typedef struct {
        int idx;
        int age;
        int at_rem;
    } wr_t;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  ages  [16];
    int  ref_w [16];
    int  rem;
    bit  missed_m;
    bit  post_prev;
    wr_t q[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rule(input int w, input int a);
        if (a <= 3) return (w + 1 > 15) ? 15 : w + 1;
        if (a < 7)  return (w - 1 < 0) ? 0 : w - 1;
        return w;
    endfunction

    function automatic int td_exp(input int a);
        if (a <= 3) return a;
        if (a < 7)  return (3 - a) & 7;
        return 0;
    endfunction

    task automatic model_reset();
        rem = 0;
        missed_m = 0;
        post_prev = 0;
        q.delete();
        for (int i = 0; i < 16; i++) ages[i] = 7;
    endtask

    // One clock: update the model with the inputs present at the edge, then check.
    task automatic cycle();
        bit  pr;
        bit  busy_pre;
        int  exp_w;
        wr_t e;
        @(posedge clk);
        if (!rst) begin
            pr = post && !post_prev;
            post_prev = post;
            busy_pre = (rem > 0);
            if (rem > 0) rem--;
            if (pr && busy_pre) missed_m = 1;
            else if (pr && en) begin
                rem = 49;
                for (int i = 0; i < 16; i++) q.push_back(wr_t'{i, ages[i], 47 - 3 * i});
            end
            for (int i = 0; i < 16; i++) begin
                if (spikes[i]) ages[i] = 0;
                else if (en && ages[i] < 7) ages[i]++;
                if (load_mask[i]) ref_w[i] = int'(load_vec[i]);
            end
        end
        #1;
        chk("busy", int'(busy), int'(rem > 0));
        chk("scan_done", int'(scan_done), int'(rem == 1));
        chk("missed_post", int'(missed_post), int'(missed_m));
        if (wr_en) begin
            if (q.size() == 0) chk("stray_write", 1, 0);
            else begin
                e = q.pop_front();
                exp_w = rule(ref_w[e.idx], e.age);
                chk("wr_select", int'(select), e.idx);
                chk("wr_timing", rem, e.at_rem);
                chk("wr_data", int'(wr_data), exp_w);
                chk("time_diff", int'(td) & 7, td_exp(e.age));
                ref_w[e.idx] = exp_w;
            end
        end else begin
            if (q.size() > 0 && rem <= q[0].at_rem) chk("missing_write", 0, 1);
            if (rem == 0) chk("td_idle", int'(td) & 7, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_select", int'(select), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_done", int'(scan_done), 0);
        chk("rst_missed", int'(missed_post), 0);
        chk("rst_td", int'(td) & 7, 0);
        cycle();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic spike(input int i);
        spikes[i] = 1'b1;
        cycle();
        spikes = '0;
    endtask

    task automatic post_up();
        post = 1'b1;
        cycle();
        post = 1'b0;
    endtask

    task automatic load(input int i, input int w);
        load_mask[i] = 1'b1;
        load_vec[i]  = 4'(w);
        cycle();
        load_mask = '0;
    endtask

    task automatic load_all(input int w);
        load_mask = '1;
        for (int i = 0; i < 16; i++) load_vec[i] = 4'(w);
        cycle();
        load_mask = '0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (rem > 0 && n < 200) begin
            cycle();
            n++;
        end
        if (rem > 0) chk("scan_timeout", 0, 1);
        idle(2);
    endtask

    initial begin
        en = 1'b0;
        post = 1'b0;
        spikes = '0;
        load_mask = '0;
        load_vec = '0;
        for (int i = 0; i < 16; i++) ref_w[i] = 0;
        do_reset();
        en = 1'b1;
        load_all(8);
        idle(2);

        // recent spike on synapse 1 -> potentiate; others at ceiling age keep 8
        spike(1); idle(2); post_up(); wait_idle();

        // age-5 spike on synapse 3: floor at 0, then 5 -> 4
        load(3, 0); spike(3); idle(5); post_up(); wait_idle();
        load(3, 5); spike(3); idle(5); post_up(); wait_idle();

        // weight ceiling on synapse 2
        load(2, 15); spike(2); post_up(); wait_idle();

        // second post edge around idx 7 is missed, scan still completes once
        post_up(); idle(20); post_up(); wait_idle(); idle(3);

        // enable low: post edge ignored, ages frozen
        spike(6); en = 1'b0; idle(2); post_up(); idle(5); en = 1'b1;
        post_up(); wait_idle();

        // live spike mid-scan must not affect the snapshot
        spike(4); idle(6); post_up(); idle(8); spike(4); wait_idle();
        post_up(); wait_idle();

        // reset around idx 5, then a fresh scan sees every age at ceiling
        post_up(); idle(14); do_reset();
        post_up(); wait_idle();

        // randomized traffic
        for (int it = 0; it < 1500; it++) begin
            spikes = 16'($urandom & $urandom & $urandom);
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 4) == 0) post = ~post;
            if (rem == 0 && $urandom_range(0, 15) == 0) begin
                load_mask = 16'($urandom);
                for (int i = 0; i < 16; i++) load_vec[i] = 4'($urandom_range(0, 15));
            end
            cycle();
            load_mask = '0;
        end
        spikes = '0;
        post = 1'b0;
        en = 1'b1;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/stdp_update_scheduler.md
Name: stdp_update_scheduler

Overview:
- Sequences STDP weight updates for the 16-synapse array: tracks per-synapse presynaptic spike age, detects a postsynaptic spike, then scans synapses 0..15.
- For each synapse it drives the shared weight-memory select, reads the old weight, applies the potentiation/depression rule and writes the new weight back.
- Sits between the spike shift-register outputs and the synapse weight store; the single owner of the weight mux select.

Parameters:
N_SYN, 16, number of synapses scanned (select width = 4)
W_WIDTH, 4, weight width
AGE_MAX, 7, saturating spike-age ceiling; value means "no recent spike"
LTP_WIN, 3, ages 0..LTP_WIN potentiate
W_MAX, 15, weight saturation ceiling
W_MIN, 0, weight saturation floor

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
enable  in  1  high: ages advance and scans may start
postsynapSR0  in  1  postsynaptic spike level; rising edge triggers a scan
presynap_spikes  in  16  bit i high = presynaptic spike on synapse i this cycle
select  out  4  weight-memory address / synapse mux select
weight_rd_data  in  4  weight at select, valid the cycle after select changes
weight_wr_en  out  1  one-cycle write strobe at address select
weight_wr_data  out  4  new weight, valid with weight_wr_en
time_difference  out  3 signed  clipped age of synapse under update; 0 when idle
busy  out  1  high from scan start through DONE
scan_done  out  1  one-cycle pulse at end of scan
missed_post  out  1  sticky: post edge arrived while busy

Behaviour:
- Reset values: select=0, weight_wr_en=0, weight_wr_data=0, time_difference=0, busy=0, scan_done=0, missed_post=0, all ages=AGE_MAX, FSM=IDLE, post edge register=0. Reset mid-scan aborts the scan; no write is issued.
- Age counter i, 3-bit:
  - presynap_spikes[i]=1 clears it to 0; clear wins over increment.
  - Otherwise, when enable=1, it increments, saturating at AGE_MAX.
  - enable=0 freezes it.
- Edge detect: post_rise = postsynapSR0 & ~postsynapSR0_q, where postsynapSR0_q is registered every cycle.
- FSM states IDLE, SEL, READ, WRITE, DONE:
  - IDLE: on post_rise & enable, snapshot all 16 ages, idx=0, busy=1, go to SEL. post_rise with enable=0 is ignored, not counted as missed.
  - SEL: select=idx; go to READ.
  - READ: capture weight_rd_data into w_old; compute w_new from snapshot age a[idx]; go to WRITE.
  - WRITE: weight_wr_en=1, weight_wr_data=w_new. If idx==N_SYN-1 go to DONE, else idx+1 and go to SEL.
  - DONE: scan_done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- Latency: 3 cycles per synapse. The first write occurs 3 cycles after the post edge is sampled; a full scan lasts 48 cycles plus 1 cycle of DONE.
- Update rule, using the snapshot age a:
  - a<=LTP_WIN: w_new = min(w_old+1, W_MAX).
  - LTP_WIN<a<AGE_MAX: w_new = max(w_old-1, W_MIN).
  - a==AGE_MAX: w_new = w_old. The write is still issued, keeping the scan timing fixed.
- time_difference:
  - In READ/WRITE: +a when a<=3; -(a-LTP_WIN) when LTP_WIN<a<AGE_MAX (range -1..-3); 0 when a==AGE_MAX.
  - 0 in IDLE/SEL/DONE.
- Live ages keep updating during a scan; the scan uses only the snapshot.
- post_rise in any state other than IDLE sets missed_post, which clears only on reset. A post_rise in the same cycle as DONE is missed; no back-to-back restart.
- select holds its last value after the scan and returns to 0 only on reset.

Decomposition:
- Shared package stdp_pkg: FSM state enum, N_SYN, W_WIDTH, AGE_MAX, LTP_WIN, W_MAX, W_MIN, age type (3-bit), weight type.
- Sub-module spike_age_counter: one per synapse, 16 instances via generate. Ports: clock, reset, enable, spike, age[2:0].
- FSM and update arithmetic live in the top module.

Test Plan:
- Reset pulse 10 ns mid-scan (at idx=5) -> weight_wr_en stays 0 afterwards, busy=0, all ages=7, select=0.
- Synapse 1 spikes, post rises 2 cycles later, memory preloaded with all 8 -> synapse 1 write=9 with time_difference=+2; untouched synapses (age 7) write 8.
- Synapse 3 spikes, post rises 5 cycles later, weight 0 -> write 0 (floor) with time_difference=-2. Same spike timing with weight 5 -> write 4.
- Synapse 2 weight 15, spike 1 cycle before post -> write 15 (ceiling). Separately, count weight_wr_en pulses = 16 and scan_done asserted exactly 49 cycles after the post edge.
- Second post rise at idx=7 -> missed_post=1 and sticky, current scan completes unchanged, no second scan starts.
- enable=0 with post rising -> no scan and ages frozen. Presynaptic spike on synapse 4 mid-scan -> live age 0, but the synapse 4 update uses the snapshot value.
